cv_mem_responder: RTL and testbench

CV_MEM_RESPONDER -- requirements
Module: cv_mem_responder

---
 rtl/cv_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_cv_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_mem_responder.sv
// cv_mem_responder: single-port word memory answering one read or write at
// a time with fixed, parameterised response latencies (RD_LAT / WR_LAT).
//
// Handshake: the requester raises rvalid (or wvalid) with its address/data
// and holds them until the matching one-cycle rready (wready) pulse; the
// request is taken only while idle, its inputs are captured at that edge,
// and later input changes or a dropped valid do not affect it. Write wins
// when both valids are seen in the same idle cycle.
//
// Optional feature macro: CV_MEM_ADDR_CHECK_EN. When defined, addresses at
// or beyond 2^DEPTH_LOG2 read back 32'hDEADBEEF, writes to them are dropped,
// the ready pulse still happens, and the sticky addr_err output is set.
// When undefined, addresses wrap onto the low DEPTH_LOG2 bits.
// dbg_state exposes the FSM state (S_IDLE=0, S_RD=1, S_WR=2, S_RESP=3).
module cv_mem_responder #(
  parameter int DEPTH_LOG2 = 16,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rvalid,
  input  logic [25:0] raddr,
  output logic        rready,
  output logic [31:0] rdata,
  input  logic        wvalid,
  input  logic [25:0] waddr,
  input  logic [31:0] wdata,
  output logic        wready,
`ifdef CV_MEM_ADDR_CHECK_EN
  output logic        addr_err,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Counter preload: the accept cycle itself counts as the first latency cycle.
  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [25:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        op_wr_q, op_wr_d;
  logic        resp_enter;

  logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [31:0]           rd_word;
  logic                  mem_we;

  assign dbg_state = state_q;

  // The access at response entry uses the *next* captured values so that a
  // latency of 1 (straight from idle to response) sees the live inputs.
  assign mem_idx = DEPTH_LOG2'(addr_d);

`ifdef CV_MEM_ADDR_CHECK_EN
  logic addr_oor;
  assign addr_oor = ({1'b0, addr_d} >= (27'd1 << DEPTH_LOG2));
  assign rd_word  = addr_oor ? 32'hDEADBEEF : mem[mem_idx];
  assign mem_we   = resp_enter & op_wr_d & ~addr_oor & ~rst;
`else
  assign rd_word  = mem[mem_idx];
  assign mem_we   = resp_enter & op_wr_d & ~rst;
`endif

  // Next-state, capture and latency countdown.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    resp_enter = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wvalid) begin
          op_wr_d = 1'b1;
          addr_d  = waddr;
          wdata_d = wdata;
          if (WR_LAT == 1) begin
            state_d    = S_RESP;
            cnt_d      = 4'd0;
            resp_enter = 1'b1;
          end else begin
            state_d = S_WR;
            cnt_d   = WR_CNT;
          end
        end else if (rvalid) begin
          op_wr_d = 1'b0;
          addr_d  = raddr;
          if (RD_LAT == 1) begin
            state_d    = S_RESP;
            cnt_d      = 4'd0;
            resp_enter = 1'b1;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_CNT;
          end
        end
      end
      S_RD, S_WR: begin
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          cnt_d      = 4'd0;
          resp_enter = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, capture registers, ready pulses and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 26'd0;
      wdata_q <= 32'd0;
      op_wr_q <= 1'b0;
      rready  <= 1'b0;
      wready  <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rready  <= resp_enter & ~op_wr_d;
      wready  <= resp_enter & op_wr_d;
      if (resp_enter && !op_wr_d) rdata <= rd_word;
    end
  end

  // Write commit on the edge entering the response; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= wdata_d;
  end

`ifdef CV_MEM_ADDR_CHECK_EN
  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) addr_err <= 1'b0;
    else if (resp_enter && addr_oor) addr_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cv_mem_responder.sv
// Bench for cv_mem_responder. Two instances with DEPTH_LOG2=4:
//   unit 0: RD_LAT=2, WR_LAT=1    unit 1: RD_LAT=1, WR_LAT=3
// A reference model (array memory + latency arithmetic) predicts each
// response when the request is issued; a negedge monitor pops and compares.
module tb_cv_mem_responder;

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        rvalid [2];
  logic [25:0] raddr  [2];
  logic        rready [2];
  logic [31:0] rdata  [2];
  logic        wvalid [2];
  logic [25:0] waddr  [2];
  logic [31:0] wdata  [2];
  logic        wready [2];
  logic [1:0]  dbg    [2];
`ifdef CV_MEM_ADDR_CHECK_EN
  logic        addr_err [2];
`endif

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cv_mem_responder #(.DEPTH_LOG2(4), .RD_LAT(2), .WR_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .rvalid(rvalid[0]), .raddr(raddr[0]),
    .rready(rready[0]), .rdata(rdata[0]), .wvalid(wvalid[0]), .waddr(waddr[0]),
    .wdata(wdata[0]), .wready(wready[0]),
`ifdef CV_MEM_ADDR_CHECK_EN
    .addr_err(addr_err[0]),
`endif
    .dbg_state(dbg[0])
  );

  cv_mem_responder #(.DEPTH_LOG2(4), .RD_LAT(1), .WR_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .rvalid(rvalid[1]), .raddr(raddr[1]),
    .rready(rready[1]), .rdata(rdata[1]), .wvalid(wvalid[1]), .waddr(waddr[1]),
    .wdata(wdata[1]), .wready(wready[1]),
`ifdef CV_MEM_ADDR_CHECK_EN
    .addr_err(addr_err[1]),
`endif
    .dbg_state(dbg[1])
  );

  // Scoreboard state and reference model
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  logic [31:0] mm [2][16];
  logic        merr [2];
  logic [31:0] last_rd [2];
  int unsigned free_at [2];
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  function automatic int unsigned lat_of(int u, bit wr);
    if (u == 0) return wr ? 1 : 2;
    return wr ? 3 : 1;
  endfunction

  // Predicts one transaction accepted in cycle acc; returns its pulse cycle.
  function automatic int unsigned model_txn(int u, bit wr, logic [25:0] a,
                                            logic [31:0] d, int unsigned acc);
    exp_t       e;
    logic [3:0] idx;
    idx    = 4'(a % 26'd16);
    e.wr   = wr;
    e.due  = 32'(acc + lat_of(u, wr));
    e.data = 32'd0;
`ifdef CV_MEM_ADDR_CHECK_EN
    if (a >= 26'd16) begin
      merr[u] = 1'b1;
      if (!wr) e.data = 32'hDEADBEEF;
    end else begin
      if (wr) mm[u][idx] = d;
      else    e.data = mm[u][idx];
    end
`else
    if (wr) mm[u][idx] = d;
    else    e.data = mm[u][idx];
`endif
    e.err = merr[u];
    if (u == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    free_at[u] = e.due + 1;
    return e.due;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_reset(int u);
    chk($sformatf("u%0d_rst_rready", u), {31'd0, rready[u]}, 32'd0);
    chk($sformatf("u%0d_rst_wready", u), {31'd0, wready[u]}, 32'd0);
    chk($sformatf("u%0d_rst_rdata", u), rdata[u], 32'd0);
    chk($sformatf("u%0d_rst_state", u), {30'd0, dbg[u]}, 32'd0);
`ifdef CV_MEM_ADDR_CHECK_EN
    chk($sformatf("u%0d_rst_addr_err", u), {31'd0, addr_err[u]}, 32'd0);
`endif
  endtask

  // Monitor: pops and compares on every ready pulse; checks rdata holding.
  task automatic mon(int u);
    exp_t e;
    bit   empty;
    if (rst[u]) return;
    if (rready[u] || wready[u]) begin
      empty = (u == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
        checks++;
        failures++;
        $display("FAIL u%0d_unexpected_pulse actual=r%0b/w%0b required=none (cycle %0d)",
                 u, rready[u], wready[u], cyc);
      end else begin
        e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("u%0d_kind", u), {30'd0, wready[u], rready[u]}, {30'd0, e.wr, ~e.wr});
        chk($sformatf("u%0d_pulse_cycle", u), cyc, e.due);
        if (!e.wr) begin
          chk($sformatf("u%0d_rdata", u), rdata[u], e.data);
          last_rd[u] = e.data;
        end
`ifdef CV_MEM_ADDR_CHECK_EN
        chk($sformatf("u%0d_addr_err", u), {31'd0, addr_err[u]}, {31'd0, e.err});
`endif
      end
    end
    if (!rready[u]) chk($sformatf("u%0d_rdata_hold", u), rdata[u], last_rd[u]);
  endtask

  always @(negedge clk) begin
    if (mon_en) for (int u = 0; u < 2; u++) mon(u);
  end

  // Driver tasks
  task automatic scramble(int u);
    rvalid[u] = 1'($urandom_range(0, 1));
    wvalid[u] = 1'($urandom_range(0, 1));
    raddr[u]  = 26'($urandom);
    waddr[u]  = 26'($urandom);
    wdata[u]  = $urandom;
  endtask

  task automatic idle(int u, int n);
    rvalid[u] = 1'b0;
    wvalid[u] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(int u, int unsigned acc, bit scr);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (rready[u] || wready[u]) got = 1'b1;
      else if (scr && cyc > acc) scramble(u);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL u%0d_timeout actual=no_pulse required=pulse (cycle %0d)", u, cyc);
    end
  endtask

  task automatic issue(int u, bit wr, logic [25:0] a, logic [31:0] d, bit scr);
    int unsigned acc;
    int unsigned due;
    acc = (cyc > free_at[u]) ? cyc : free_at[u];
    due = model_txn(u, wr, a, d, acc);
    if (wr) begin
      wvalid[u] = 1'b1; waddr[u] = a; wdata[u] = d; rvalid[u] = 1'b0;
    end else begin
      rvalid[u] = 1'b1; raddr[u] = a; wvalid[u] = 1'b0;
    end
    wait_pulse(u, acc, scr);
    if (due == 0) $display("unreachable");
  endtask

  // Both valids rise together: write first, read accepted after its pulse.
  task automatic issue_both(int u, logic [25:0] a, logic [31:0] d);
    int unsigned acc;
    int unsigned wdue;
    int unsigned rdue;
    acc  = (cyc > free_at[u]) ? cyc : free_at[u];
    wdue = model_txn(u, 1'b1, a, d, acc);
    rdue = model_txn(u, 1'b0, a, 32'd0, wdue + 1);
    wvalid[u] = 1'b1; waddr[u] = a; wdata[u] = d;
    rvalid[u] = 1'b1; raddr[u] = a;
    wait_pulse(u, acc, 1'b0);
    wvalid[u] = 1'b0;
    wait_pulse(u, wdue + 1, 1'b0);
    if (rdue == 0) $display("unreachable");
  endtask

  // Reset in the cycle after accept: the transaction must vanish.
  task automatic reset_mid(int u, bit wr);
    idle(u, 1);
    if (wr) begin
      wvalid[u] = 1'b1; waddr[u] = 26'd7; wdata[u] = 32'd1;
    end else begin
      rvalid[u] = 1'b1; raddr[u] = 26'd7;
    end
    @(negedge clk);
    rst[u] = 1'b1;
    @(negedge clk);
    chk_reset(u);
    last_rd[u] = 32'd0;
    merr[u]    = 1'b0;
    rst[u]     = 1'b0;
    free_at[u] = cyc;
    idle(u, 4);
    issue(u, 1'b0, 26'd7, 32'd0, 1'b0);
  endtask

  task automatic run_unit(int u);
    for (int i = 0; i < 16; i++) issue(u, 1'b1, 26'(i), $urandom, 1'b0);
    issue(u, 1'b1, 26'd5, 32'h12345678, 1'b0);
    issue(u, 1'b0, 26'd5, 32'd0, 1'b0);
    idle(u, 2);
    issue_both(u, 26'd5, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) issue(u, 1'b0, 26'(i), 32'd0, 1'b0);
    issue(u, 1'b0, 26'h13, 32'd0, 1'b0);
    issue(u, 1'b1, 26'h1A, 32'hCAFE0001, 1'b0);
    issue(u, 1'b0, 26'd10, 32'd0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 3) == 0) idle(u, $urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0)
        issue_both(u, 26'($urandom_range(0, 31)), $urandom);
      else
        issue(u, 1'($urandom_range(0, 1)), 26'($urandom_range(0, 31)), $urandom, 1'b1);
    end
    issue(u, 1'b1, 26'd7, 32'h00000777, 1'b0);
    reset_mid(u, u == 1);
    idle(u, 3);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; rvalid[u] = 1'b0; wvalid[u] = 1'b0;
      raddr[u] = 26'd0; waddr[u] = 26'd0; wdata[u] = 32'd0;
      last_rd[u] = 32'd0; merr[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk_reset(u);
      rst[u] = 1'b0;
      free_at[u] = cyc;
    end
    mon_en = 1'b1;
    run_unit(0);
    run_unit(1);
    idle(0, 5);
    chk("u0_queue_drained", exp_q0.size(), 32'd0);
    chk("u1_queue_drained", exp_q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
